serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial unsigned adder that adds two WIDTH-bit operands one bit per clock, LSB first. Each bit is processed by a full-adder cell built from two `Half_Adder` instances, with the carry held in a flip-flop between bits. The block sits upstream of result consumers as the sequential wrapper around the half-adder cell. It trades WIDTH cycles of latency for a single-bit datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: request a new addition; sampled only when `busy`=0.
- `a`  in  WIDTH: operand A; captured on the accepting edge.
- `b`  in  WIDTH: operand B; captured on the accepting edge.
- `busy`  out  1: high while an operation is in flight (SHIFT or DONE).
- `done`  out  1: one-cycle pulse; `sum` and `ca` are valid and new.
- `sum`  out  WIDTH: result, a+b modulo 2^WIDTH; holds until the next result.
- `ca`  out  1: carry out of the MSB; holds with `sum`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. The state is encoded in registers.
- Bit cell:
  - HA1(a_bit, b_bit) gives s1 and c1.
  - HA2(s1, carry_q) gives bit_sum and c2.
  - carry_d = c1 | c2.
- IDLE:
  - `busy`=0 and `done`=0.
  - If `start`=1, the block loads `a` into shift register A and `b` into shift register B.
  - On that load it clears carry_q and the bit counter, clears the internal sum shift register, and moves to SHIFT.
- SHIFT:
  - `busy`=1.
  - Each cycle processes bit[0] of the A and B shift registers.
  - The A and B shift registers shift right by one.
  - The sum shift register shifts right with bit_sum inserted at the MSB.
  - carry_q is updated to carry_d, and the counter increments.
- SHIFT exit: on the edge where the counter equals WIDTH-1 (the last bit):
  - The full sum (including the final bit_sum) is written to the `sum` output register.
  - carry_d is written to `ca`.
  - The state goes to DONE.
- DONE:
  - `busy`=1 and `done`=1 for exactly one cycle.
  - The state then returns to IDLE unconditionally.
- `start` while `busy`=1 is ignored. It is not queued, and the operand inputs are not re-sampled.
- The counter width is $clog2(WIDTH). The counter never wraps during normal operation.
- Arithmetic is unsigned: {`ca`,`sum`} = a + b exactly, i.e. (WIDTH+1) bits.
- Reset (`rst_n`=0 at a rising edge), from any state including mid-SHIFT:
  - The state goes to IDLE.
  - `busy`, `done`, `sum`, `ca`, carry_q, the counter and all shift registers are cleared to 0.
  - The in-flight operation is discarded and no `done` pulse is produced.
- `sum` and `ca` are updated only on SHIFT exit. Between results they hold the last value, or 0 after reset.

## Timing
- Let edge k be the edge where IDLE samples `start`=1.
- `busy` rises after edge k.
- Bits 0..WIDTH-1 are processed on edges k+1..k+WIDTH.
- `sum`, `ca` and `done` change after edge k+WIDTH. `done` is high for the single cycle between edges k+WIDTH and k+WIDTH+1.
- `busy` falls after edge k+WIDTH+1, when the FSM is back in IDLE.
- The earliest next accept is edge k+WIDTH+2.
- Throughput is one addition per WIDTH+2 cycles.
- Outputs are registered: there are no combinational paths from inputs to outputs.
- Reset values: `busy`=0, `done`=0, `sum`=0, `ca`=0.

## Test plan
- Basic add, WIDTH=8: a=3, b=5, pulse `start`.
  - `done` occurs exactly 8 cycles after the accepting edge, with `sum`=8 and `ca`=0.
  - `busy` is high for 9 cycles.
- Carry ripple to MSB: a=255, b=1 → `sum`=0, `ca`=1.
- Maximum inputs: a=255, b=255 → `sum`=254, `ca`=1.
- Zero inputs: a=0, b=0 → `sum`=0, `ca`=0, `done` pulse width 1 cycle.
- Busy protection, in three steps:
  - Start a=10, b=20.
  - During SHIFT, assert `start` with a=100, b=100 → the result is `sum`=30, `ca`=0 and there is only one `done` pulse.
  - Holding `start` high continuously accepts again at edge k+WIDTH+2.
- Reset mid-operation, in three steps:
  - Start a=200, b=100.
  - Drive `rst_n`=0 for one edge at bit 4 → `busy`=0, `done`=0, `sum`=0, `ca`=0, and no `done` pulse follows.
  - A subsequent a=1, b=2 yields `sum`=3.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell (two Half_Adder instances)
// walks WIDTH-bit operands LSB first, carrying between bits in a flip-flop.

module Half_Adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             ca
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ca_q, ca_d;

   logic             s1, c1, c2;
   logic             bit_sum, bit_carry;
   logic [WIDTH-1:0] sum_full;

   Half_Adder u_ha1 (
      .a (a_sh_q[0]),
      .b (b_sh_q[0]),
      .s (s1),
      .c (c1)
   );

   Half_Adder u_ha2 (
      .a (s1),
      .b (carry_q),
      .s (bit_sum),
      .c (c2)
   );

   assign bit_carry = c1 | c2;

   // Only WIDTH-1 result bits need storing: the final bit comes straight from
   // the cell on the exit edge, so the full sum is {bit_sum, sum_sh_q}.
   assign sum_full = {bit_sum, sum_sh_q};

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      ca_d     = ca_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               sum_sh_d = '0;
               carry_d  = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = sum_full[WIDTH-1:1];
            carry_d  = bit_carry;
            if (cnt_q == LAST_BIT) begin
               sum_d   = sum_full;
               ca_d    = bit_carry;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         ca_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         ca_q     <= ca_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign ca   = ca_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes hand-computed results,
// a negedge monitor pops and checks them whenever done pulses.

module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       ca;

   typedef struct {
      logic [8:0]  res;
      int unsigned cyc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int unsigned compared   = 0;
   int unsigned mismatched = 0;
   int unsigned cyc        = 0;
   int unsigned done_cnt   = 0;
   logic        done_prev  = 1'b0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .ca    (ca)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] expv);
      compared++;
      if (act !== expv) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         if (done_prev === 1'b1) check("done_width", 32'd2, 32'd1);
         if (sb_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("result", 32'({ca, sum}), 32'(mon_e.res));
            check("latency", cyc, mon_e.cyc);
         end
      end
      done_prev = done;
   end

   task automatic add_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [8:0] expv);
      int unsigned n;
      int unsigned g;
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      sb_q.push_back('{expv, cyc + 1 + 8});
      @(negedge clk);
      start = 1'b0;
      n = 0;
      g = 0;
      while (busy === 1'b1 && g < 60) begin
         n++;
         g++;
         @(negedge clk);
      end
      check("busy_cycles", n, 32'd9);
   endtask

   initial begin
      int unsigned k;
      int unsigned g;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum",  32'(sum),  32'd0);
      check("rst_ca",   32'(ca),   32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      add_op(8'd3, 8'd5, 9'd8);
      repeat (3) @(negedge clk);
      check("sum_hold", 32'(sum), 32'd8);
      add_op(8'd255, 8'd1,   9'd256);
      add_op(8'd255, 8'd255, 9'd510);
      add_op(8'd0,   8'd0,   9'd0);

      // start during SHIFT is ignored; held start re-accepts at k+10
      @(negedge clk);
      a     = 8'd10;
      b     = 8'd20;
      start = 1'b1;
      k     = cyc + 1;
      sb_q.push_back('{9'd30, k + 8});
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a     = 8'd100;
      b     = 8'd100;
      start = 1'b1;
      sb_q.push_back('{9'd200, k + 10 + 8});
      g = 0;
      while (cyc < k + 10 && g < 60) begin
         @(negedge clk);
         g++;
      end
      start = 1'b0;
      check("reaccept_busy", 32'(busy), 32'd1);
      g = 0;
      while (busy === 1'b1 && g < 60) begin
         @(negedge clk);
         g++;
      end
      check("idle_after_reaccept", 32'(busy), 32'd0);

      // reset on the edge that would process bit 4
      @(negedge clk);
      a     = 8'd200;
      b     = 8'd100;
      start = 1'b1;
      k     = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      g = 0;
      while (cyc < k + 4 && g < 60) begin
         @(negedge clk);
         g++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum",  32'(sum),  32'd0);
      check("midrst_ca",   32'(ca),   32'd0);
      repeat (12) @(negedge clk);
      add_op(8'd1, 8'd2, 9'd3);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);
      check("done_count", done_cnt, 32'd7);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
